// File: rtl/pqsdn_ram_rw_arb.sv
// pqsdn_ram_rw_arb: round-robin write/read arbiter with write forwarding for a 1W/1R table RAM
module pqsdn_ram_rw_arb #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req0_i,
  input  logic              wr_req1_i,
  input  logic [ADDR_W-1:0] wr_addr0_i,
  input  logic [ADDR_W-1:0] wr_addr1_i,
  input  logic [DATA_W-1:0] wr_data0_i,
  input  logic [DATA_W-1:0] wr_data1_i,
  output logic              wr_gnt0_o,
  output logic              wr_gnt1_o,
  input  logic              rd_req0_i,
  input  logic              rd_req1_i,
  input  logic [ADDR_W-1:0] rd_addr0_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  output logic              rd_gnt0_o,
  output logic              rd_gnt1_o,
  output logic              rd_vld0_o,
  output logic              rd_vld1_o,
  output logic [DATA_W-1:0] rd_data0_o,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic              ram_en_a_o,
  output logic [ADDR_W-1:0] ram_wraddr_a_o,
  output logic [DATA_W-1:0] ram_wrdata_a_o,
  output logic              ram_rden_b_o,
  output logic [ADDR_W-1:0] ram_rdaddr_b_o,
  input  logic [DATA_W-1:0] ram_rddata_i
);
  logic              wr_ptr;
  logic              rd_ptr;
  logic              fwd_vld;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] rd_sel;
  // grants (forced low in reset), RAM port muxing and hazard-aware read data selection
  always_comb begin
    wr_gnt0_o      = rst_n & wr_req0_i & (~wr_req1_i | ~wr_ptr);
    wr_gnt1_o      = rst_n & wr_req1_i & (~wr_req0_i | wr_ptr);
    rd_gnt0_o      = rst_n & rd_req0_i & (~rd_req1_i | ~rd_ptr);
    rd_gnt1_o      = rst_n & rd_req1_i & (~rd_req0_i | rd_ptr);
    ram_en_a_o     = wr_gnt0_o | wr_gnt1_o;
    ram_wraddr_a_o = wr_gnt0_o ? wr_addr0_i : wr_gnt1_o ? wr_addr1_i : '0;
    ram_wrdata_a_o = wr_gnt0_o ? wr_data0_i : wr_gnt1_o ? wr_data1_i : '0;
    ram_rden_b_o   = rd_gnt0_o | rd_gnt1_o;
    ram_rdaddr_b_o = rd_gnt0_o ? rd_addr0_i : rd_gnt1_o ? rd_addr1_i : '0;
    rd_sel         = (ram_en_a_o && ram_wraddr_a_o == ram_rdaddr_b_o) ? ram_wrdata_a_o :
                     (fwd_vld && fwd_addr == ram_rdaddr_b_o) ? fwd_data : ram_rddata_i;
  end
  // round-robin pointers move to the loser of each grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (ram_en_a_o) wr_ptr <= wr_gnt0_o;
      if (ram_rden_b_o) rd_ptr <= rd_gnt0_o;
    end
  end
  // shadow of the RAM's internal write register, valid the cycle after a write grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_vld  <= 1'b0;
      fwd_addr <= '0;
      fwd_data <= '0;
    end else begin
      fwd_vld  <= ram_en_a_o;
      fwd_addr <= ram_wraddr_a_o;
      fwd_data <= ram_wrdata_a_o;
    end
  end
  // registered read return to whichever reader was granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld0_o  <= 1'b0;
      rd_vld1_o  <= 1'b0;
      rd_data0_o <= '0;
      rd_data1_o <= '0;
    end else begin
      rd_vld0_o <= rd_gnt0_o;
      rd_vld1_o <= rd_gnt1_o;
      if (rd_gnt0_o) rd_data0_o <= rd_sel;
      if (rd_gnt1_o) rd_data1_o <= rd_sel;
    end
  end
endmodule

// File: tb/tb_pqsdn_ram_rw_arb.sv
// tb_pqsdn_ram_rw_arb: directed and random checks of the RAM arbiter against a logical-memory model
module tb_pqsdn_ram_rw_arb;
  logic        clk = 0;
  logic        rst_n = 1;
  logic        wr_req0 = 0, wr_req1 = 0, rd_req0 = 0, rd_req1 = 0;
  logic [9:0]  wr_addr0 = 0, wr_addr1 = 0, rd_addr0 = 0, rd_addr1 = 0;
  logic [63:0] wr_data0 = 0, wr_data1 = 0;
  logic        wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1, rd_vld0, rd_vld1;
  logic [63:0] rd_data0, rd_data1;
  logic        ram_en_a, ram_rden_b;
  logic [9:0]  ram_wraddr_a, ram_rdaddr_b;
  logic [63:0] ram_wrdata_a, ram_rddata;
  logic [63:0] mem [1024];
  logic        ram_wv;
  logic [9:0]  ram_wa;
  logic [63:0] ram_wd;
  logic [63:0] cur [1024];
  int          last_w = 1, last_r = 1;
  bit          pend_v = 0;
  logic [9:0]  pend_a = 0;
  logic [63:0] pend_old = 0;
  bit          ev0 = 0, ev1 = 0;
  logic [63:0] ed0 = 0, ed1 = 0;
  int          vec = 0, miss = 0;
  logic [9:0]  lost_a;

  pqsdn_ram_rw_arb dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req0_i(wr_req0), .wr_req1_i(wr_req1),
    .wr_addr0_i(wr_addr0), .wr_addr1_i(wr_addr1),
    .wr_data0_i(wr_data0), .wr_data1_i(wr_data1),
    .wr_gnt0_o(wr_gnt0), .wr_gnt1_o(wr_gnt1),
    .rd_req0_i(rd_req0), .rd_req1_i(rd_req1),
    .rd_addr0_i(rd_addr0), .rd_addr1_i(rd_addr1),
    .rd_gnt0_o(rd_gnt0), .rd_gnt1_o(rd_gnt1),
    .rd_vld0_o(rd_vld0), .rd_vld1_o(rd_vld1),
    .rd_data0_o(rd_data0), .rd_data1_o(rd_data1),
    .ram_en_a_o(ram_en_a), .ram_wraddr_a_o(ram_wraddr_a), .ram_wrdata_a_o(ram_wrdata_a),
    .ram_rden_b_o(ram_rden_b), .ram_rdaddr_b_o(ram_rdaddr_b), .ram_rddata_i(ram_rddata)
  );

  always #5 clk = ~clk;

  // RAM with a registered write (array updated one edge after capture) and asynchronous read
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ram_wv <= 1'b0;
    else begin
      ram_wv <= ram_en_a;
      ram_wa <= ram_wraddr_a;
      ram_wd <= ram_wrdata_a;
      if (ram_wv) mem[ram_wa] <= ram_wd;
    end
  end
  assign ram_rddata = mem[ram_rdaddr_b];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit wg0, wg1, rg0, rg1;
    logic [9:0] wa, ra;
    logic [63:0] wd;
    @(negedge clk);
    #1;
    wg0 = wr_req0 && (!wr_req1 || last_w == 1);
    wg1 = wr_req1 && !wg0;
    rg0 = rd_req0 && (!rd_req1 || last_r == 1);
    rg1 = rd_req1 && !rg0;
    wa = wg0 ? wr_addr0 : wg1 ? wr_addr1 : 10'd0;
    wd = wg0 ? wr_data0 : wg1 ? wr_data1 : 64'd0;
    ra = rg0 ? rd_addr0 : rg1 ? rd_addr1 : 10'd0;
    chk("wr_gnt0", wr_gnt0, wg0);
    chk("wr_gnt1", wr_gnt1, wg1);
    chk("rd_gnt0", rd_gnt0, rg0);
    chk("rd_gnt1", rd_gnt1, rg1);
    chk("ram_en_a", ram_en_a, wg0 | wg1);
    chk("ram_wraddr", ram_wraddr_a, wa);
    chk("ram_wrdata", ram_wrdata_a, wd);
    chk("ram_rden_b", ram_rden_b, rg0 | rg1);
    chk("ram_rdaddr", ram_rdaddr_b, ra);
    @(posedge clk);
    pend_v = 0;
    if (wg0 || wg1) begin
      pend_v = 1;
      pend_a = wa;
      pend_old = cur[wa];
      cur[wa] = wd;
      last_w = wg0 ? 0 : 1;
    end
    if (rg0 || rg1) last_r = rg0 ? 0 : 1;
    ev0 = rg0;
    ev1 = rg1;
    if (rg0) ed0 = cur[ra];
    if (rg1) ed1 = cur[ra];
    #1;
    chk("rd_vld0", rd_vld0, ev0);
    chk("rd_vld1", rd_vld1, ev1);
    chk("rd_data0", rd_data0, ed0);
    chk("rd_data1", rd_data1, ed1);
  endtask

  task automatic idle();
    wr_req0 = 0; wr_req1 = 0; rd_req0 = 0; rd_req1 = 0;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    foreach (cur[i]) cur[i] = '0;
    wr_req0 = 1; wr_req1 = 1; rd_req0 = 1; rd_req1 = 1;
    #1 rst_n = 0;
    #2;
    chk("rst_wr_gnt0", wr_gnt0, 0);
    chk("rst_wr_gnt1", wr_gnt1, 0);
    chk("rst_rd_gnt0", rd_gnt0, 0);
    chk("rst_rd_gnt1", rd_gnt1, 0);
    chk("rst_ram_en", ram_en_a, 0);
    chk("rst_ram_rden", ram_rden_b, 0);
    chk("rst_rd_vld0", rd_vld0, 0);
    chk("rst_rd_vld1", rd_vld1, 0);
    chk("rst_rd_data0", rd_data0, 0);
    chk("rst_rd_data1", rd_data1, 0);
    @(posedge clk);
    #1 rst_n = 1;
    // contention fairness from reset: writers and readers both alternate starting at 0
    wr_addr0 = 10'h100; wr_data0 = 64'h1000; wr_addr1 = 10'h101; wr_data1 = 64'h1001;
    rd_addr0 = 10'h100; rd_addr1 = 10'h101;
    for (int i = 0; i < 6; i++) begin
      wr_data0 = 64'h1000 + 64'(i);
      wr_data1 = 64'h2000 + 64'(i);
      cyc();
    end
    idle();
    // single writer, read back several cycles later
    wr_req0 = 1; wr_addr0 = 10'h010; wr_data0 = 64'hA5;
    cyc();
    idle();
    repeat (3) cyc();
    rd_req0 = 1; rd_addr0 = 10'h010;
    cyc();
    idle();
    chk("single_rd_data0", rd_data0, 64'hA5);
    // same-cycle forward
    wr_req1 = 1; wr_addr1 = 10'h3FF; wr_data1 = 64'h1;
    rd_req0 = 1; rd_addr0 = 10'h3FF;
    cyc();
    idle();
    chk("fwd_same_data0", rd_data0, 64'h1);
    // previous-cycle forward, and a neighbouring address going to the RAM
    wr_req0 = 1; wr_addr0 = 10'h020; wr_data0 = 64'h55;
    cyc();
    idle();
    rd_req1 = 1; rd_addr1 = 10'h020;
    cyc();
    idle();
    chk("fwd_prev_data1", rd_data1, 64'h55);
    wr_req0 = 1; wr_addr0 = 10'h020; wr_data0 = 64'h66;
    cyc();
    idle();
    rd_req0 = 1; rd_addr0 = 10'h021;
    cyc();
    idle();
    chk("fwd_miss_data0", rd_data0, 64'h0);
    // back-to-back overwrite
    wr_req0 = 1; wr_addr0 = 10'h040; wr_data0 = 64'h11;
    cyc();
    wr_data0 = 64'h22; rd_req0 = 1; rd_addr0 = 10'h040;
    cyc();
    idle();
    chk("ovw_n1_data0", rd_data0, 64'h22);
    rd_req1 = 1; rd_addr1 = 10'h040;
    cyc();
    idle();
    chk("ovw_n2_data1", rd_data1, 64'h22);
    // random traffic on a small address window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      wr_req0 = 1'($urandom); wr_req1 = 1'($urandom);
      rd_req0 = 1'($urandom); rd_req1 = 1'($urandom);
      wr_addr0 = 10'($urandom_range(0, 7)); wr_addr1 = 10'($urandom_range(0, 7));
      rd_addr0 = 10'($urandom_range(0, 7)); rd_addr1 = 10'($urandom_range(0, 7));
      wr_data0 = {$urandom, $urandom}; wr_data1 = {$urandom, $urandom};
      cyc();
    end
    // reset asserted mid-cycle during contention, right after a write was granted
    wr_req0 = 1; wr_req1 = 1; rd_req0 = 1; rd_req1 = 1;
    wr_addr0 = 10'h005; wr_data0 = 64'hDEAD; wr_addr1 = 10'h005; wr_data1 = 64'hBEEF;
    rd_addr0 = 10'h005; rd_addr1 = 10'h006;
    cyc();
    lost_a = pend_a;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_wr_gnt0", wr_gnt0, 0);
    chk("mid_wr_gnt1", wr_gnt1, 0);
    chk("mid_rd_gnt0", rd_gnt0, 0);
    chk("mid_rd_gnt1", rd_gnt1, 0);
    chk("mid_ram_en", ram_en_a, 0);
    chk("mid_ram_rden", ram_rden_b, 0);
    chk("mid_rd_vld0", rd_vld0, 0);
    chk("mid_rd_vld1", rd_vld1, 0);
    chk("mid_rd_data0", rd_data0, 0);
    if (pend_v) cur[pend_a] = pend_old;
    pend_v = 0;
    last_w = 1; last_r = 1;
    ev0 = 0; ev1 = 0; ed0 = 0; ed1 = 0;
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      wr_addr0 = 10'h200 + 10'(i); wr_addr1 = 10'h210 + 10'(i);
      rd_addr0 = 10'h300; rd_addr1 = 10'h301;
      cyc();
    end
    idle();
    rd_req0 = 1; rd_addr0 = lost_a;
    cyc();
    idle();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
